// File: rtl/tg68_ram_arbiter.sv
// Two-master round-robin arbiter in front of one 68000-style asynchronous-bus RAM port.
// Each access runs to completion downstream; ram_as recovery time is enforced between cycles.
module tg68_ram_arbiter #(
    parameter int unsigned AW  = 32,
    parameter int unsigned GAP = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_m0_as,
    input  logic [AW-1:0] i_m0_adr,
    input  logic          i_m0_rw,
    input  logic          i_m0_uds,
    input  logic          i_m0_lds,
    input  logic [15:0]   i_m0_dat_out,
    output logic [15:0]   o_m0_dat_in,
    output logic          o_m0_dtack,
    input  logic          i_m1_as,
    input  logic [AW-1:0] i_m1_adr,
    input  logic          i_m1_rw,
    input  logic          i_m1_uds,
    input  logic          i_m1_lds,
    input  logic [15:0]   i_m1_dat_out,
    output logic [15:0]   o_m1_dat_in,
    output logic          o_m1_dtack,
    output logic          o_ram_as,
    output logic          o_ram_rw,
    output logic          o_ram_uds,
    output logic          o_ram_lds,
    output logic [AW-1:0] o_ram_adr,
    output logic [15:0]   o_ram_dat_out,
    input  logic [15:0]   i_ram_dat_in,
    input  logic          i_ram_dtack
);

    localparam int unsigned GW = $clog2(GAP + 1);
    localparam logic [GW-1:0] GapMax = GW'(GAP);

    typedef enum logic [2:0] {
        StIdle,
        StAct0,
        StAct1,
        StDone0,
        StDone1
    } state_e;

    state_e        r_state, w_state_d;
    logic          r_last, w_last_d;
    logic [GW-1:0] r_gap, w_gap_d;
    logic          r_ram_as, w_ram_as_d;
    logic          r_ram_rw, w_ram_rw_d;
    logic          r_ram_uds, w_ram_uds_d;
    logic          r_ram_lds, w_ram_lds_d;
    logic [AW-1:0] r_ram_adr, w_ram_adr_d;
    logic [15:0]   r_ram_dat_out, w_ram_dat_out_d;
    logic [15:0]   r_m0_dat_in, w_m0_dat_in_d;
    logic [15:0]   r_m1_dat_in, w_m1_dat_in_d;
    logic          r_m0_dtack, w_m0_dtack_d;
    logic          r_m1_dtack, w_m1_dtack_d;

    logic          w_req0, w_req1, w_pick1, w_gap_ok;
    logic [GW-1:0] w_gap_inc;

    assign w_req0    = ~i_m0_as;
    assign w_req1    = ~i_m1_as;
    // On a tie the master that was not granted last wins.
    assign w_pick1   = w_req1 & (~w_req0 | ~r_last);
    assign w_gap_inc = (r_gap == GapMax) ? GapMax : r_gap + GW'(1);
    // The clock in progress counts as recovery time, so a pending grant lands exactly GAP
    // clocks after ram_as rose.
    assign w_gap_ok  = r_ram_as & (w_gap_inc == GapMax);

    always_comb begin
        w_state_d       = r_state;
        w_last_d        = r_last;
        w_gap_d         = r_ram_as ? w_gap_inc : r_gap;
        w_ram_as_d      = r_ram_as;
        w_ram_rw_d      = r_ram_rw;
        w_ram_uds_d     = r_ram_uds;
        w_ram_lds_d     = r_ram_lds;
        w_ram_adr_d     = r_ram_adr;
        w_ram_dat_out_d = r_ram_dat_out;
        w_m0_dat_in_d   = r_m0_dat_in;
        w_m1_dat_in_d   = r_m1_dat_in;
        w_m0_dtack_d    = r_m0_dtack;
        w_m1_dtack_d    = r_m1_dtack;

        unique case (r_state)
            StIdle: begin
                if (w_gap_ok && (w_req0 || w_req1)) begin
                    w_last_d        = w_pick1;
                    w_ram_as_d      = 1'b0;
                    w_ram_adr_d     = w_pick1 ? i_m1_adr     : i_m0_adr;
                    w_ram_rw_d      = w_pick1 ? i_m1_rw      : i_m0_rw;
                    w_ram_uds_d     = w_pick1 ? i_m1_uds     : i_m0_uds;
                    w_ram_lds_d     = w_pick1 ? i_m1_lds     : i_m0_lds;
                    w_ram_dat_out_d = w_pick1 ? i_m1_dat_out : i_m0_dat_out;
                    w_state_d       = w_pick1 ? StAct1 : StAct0;
                end
            end
            StAct0: begin
                if (!i_ram_dtack) begin
                    w_ram_as_d = 1'b1;
                    w_gap_d    = '0;
                    if (!i_m0_as) begin
                        if (r_ram_rw) begin
                            w_m0_dat_in_d = i_ram_dat_in;
                        end
                        w_m0_dtack_d = 1'b0;
                        w_state_d    = StDone0;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            StAct1: begin
                if (!i_ram_dtack) begin
                    w_ram_as_d = 1'b1;
                    w_gap_d    = '0;
                    if (!i_m1_as) begin
                        if (r_ram_rw) begin
                            w_m1_dat_in_d = i_ram_dat_in;
                        end
                        w_m1_dtack_d = 1'b0;
                        w_state_d    = StDone1;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            StDone0: begin
                if (i_m0_as) begin
                    w_m0_dtack_d = 1'b1;
                    w_state_d    = StIdle;
                end
            end
            StDone1: begin
                if (i_m1_as) begin
                    w_m1_dtack_d = 1'b1;
                    w_state_d    = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_last        <= 1'b1;
            r_gap         <= GapMax;
            r_ram_as      <= 1'b1;
            r_ram_rw      <= 1'b1;
            r_ram_uds     <= 1'b1;
            r_ram_lds     <= 1'b1;
            r_ram_adr     <= '0;
            r_ram_dat_out <= '0;
            r_m0_dat_in   <= '0;
            r_m1_dat_in   <= '0;
            r_m0_dtack    <= 1'b1;
            r_m1_dtack    <= 1'b1;
        end else begin
            r_state       <= w_state_d;
            r_last        <= w_last_d;
            r_gap         <= w_gap_d;
            r_ram_as      <= w_ram_as_d;
            r_ram_rw      <= w_ram_rw_d;
            r_ram_uds     <= w_ram_uds_d;
            r_ram_lds     <= w_ram_lds_d;
            r_ram_adr     <= w_ram_adr_d;
            r_ram_dat_out <= w_ram_dat_out_d;
            r_m0_dat_in   <= w_m0_dat_in_d;
            r_m1_dat_in   <= w_m1_dat_in_d;
            r_m0_dtack    <= w_m0_dtack_d;
            r_m1_dtack    <= w_m1_dtack_d;
        end
    end

    assign o_ram_as      = r_ram_as;
    assign o_ram_rw      = r_ram_rw;
    assign o_ram_uds     = r_ram_uds;
    assign o_ram_lds     = r_ram_lds;
    assign o_ram_adr     = r_ram_adr;
    assign o_ram_dat_out = r_ram_dat_out;
    assign o_m0_dat_in   = r_m0_dat_in;
    assign o_m1_dat_in   = r_m1_dat_in;
    assign o_m0_dtack    = r_m0_dtack;
    assign o_m1_dtack    = r_m1_dtack;

endmodule

// File: tb/tb_tg68_ram_arbiter.sv
// Bench for tg68_ram_arbiter: two bus masters, a two-stage-ack RAM, a word-array reference
// memory and a scoreboard monitor that checks every master acknowledge.
module tb_tg68_ram_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned GAP = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_as = 1'b1, m1_as = 1'b1;
    logic [AW-1:0] m0_adr = '0, m1_adr = '0;
    logic          m0_rw = 1'b1, m1_rw = 1'b1;
    logic          m0_uds = 1'b1, m0_lds = 1'b1, m1_uds = 1'b1, m1_lds = 1'b1;
    logic [15:0]   m0_dat_out = '0, m1_dat_out = '0;
    logic [15:0]   m0_dat_in, m1_dat_in;
    logic          m0_dtack, m1_dtack;
    logic          ram_as, ram_rw, ram_uds, ram_lds;
    logic [AW-1:0] ram_adr;
    logic [15:0]   ram_dat_out, ram_dat_in;
    logic          ram_dtack;

    always #5 clk = ~clk;

    tg68_ram_arbiter #(.AW(AW), .GAP(GAP)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_m0_as      (m0_as),
        .i_m0_adr     (m0_adr),
        .i_m0_rw      (m0_rw),
        .i_m0_uds     (m0_uds),
        .i_m0_lds     (m0_lds),
        .i_m0_dat_out (m0_dat_out),
        .o_m0_dat_in  (m0_dat_in),
        .o_m0_dtack   (m0_dtack),
        .i_m1_as      (m1_as),
        .i_m1_adr     (m1_adr),
        .i_m1_rw      (m1_rw),
        .i_m1_uds     (m1_uds),
        .i_m1_lds     (m1_lds),
        .i_m1_dat_out (m1_dat_out),
        .o_m1_dat_in  (m1_dat_in),
        .o_m1_dtack   (m1_dtack),
        .o_ram_as     (ram_as),
        .o_ram_rw     (ram_rw),
        .o_ram_uds    (ram_uds),
        .o_ram_lds    (ram_lds),
        .o_ram_adr    (ram_adr),
        .o_ram_dat_out(ram_dat_out),
        .i_ram_dat_in (ram_dat_in),
        .i_ram_dtack  (ram_dtack)
    );

    // Bench RAM: acknowledges two clocks after ram_as falls, writes the enabled lanes once.
    logic [15:0] ram_mem [0:255];
    logic        p1 = 1'b0, p2 = 1'b0;
    assign ram_dat_in = ram_mem[ram_adr[8:1]];
    assign ram_dtack  = ~(p2 & ~ram_as);

    initial begin
        for (int i = 0; i < 256; i++) ram_mem[i] = 16'h0000;
        ram_mem[8] = 16'h1234;
        ram_mem[9] = 16'h5678;
        forever begin
            @(posedge clk);
            if (p1 && !p2 && !ram_as && !ram_rw) begin
                if (!ram_uds) ram_mem[ram_adr[8:1]][15:8] <= ram_dat_out[15:8];
                if (!ram_lds) ram_mem[ram_adr[8:1]][7:0]  <= ram_dat_out[7:0];
            end
            p1 <= ~ram_as;
            p2 <= p1 & ~ram_as;
        end
    end

    // Reference model and scoreboard state.
    typedef struct packed {
        logic        rd;
        logic [15:0] data;
    } exp_t;

    logic [15:0] ref_mem [0:255];
    exp_t        q0[$], q1[$];
    int          dt_log[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          hi_run = 100;
    int          last_gap = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_as(input int m, input logic v);
        if (m == 0) m0_as = v;
        else m1_as = v;
    endtask

    // One bus cycle from master m; lat counts falling edges until dtack is seen low.
    task automatic access(input int m, input logic [AW-1:0] adr, input logic rw,
                          input logic uds, input logic lds, input logic [15:0] wdat,
                          input bit abort, output int lat);
        exp_t e;
        int   idx;
        idx    = int'(adr[8:1]);
        e.rd   = rw;
        e.data = rw ? ref_mem[idx] : 16'h0000;
        if (!rw) begin
            if (!uds) ref_mem[idx][15:8] = wdat[15:8];
            if (!lds) ref_mem[idx][7:0]  = wdat[7:0];
        end
        if (!abort) begin
            if (m == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        @(negedge clk);
        if (m == 0) begin
            m0_adr = adr; m0_rw = rw; m0_uds = uds; m0_lds = lds; m0_dat_out = wdat;
        end else begin
            m1_adr = adr; m1_rw = rw; m1_uds = uds; m1_lds = lds; m1_dat_out = wdat;
        end
        set_as(m, 1'b0);
        lat = 0;
        if (abort) begin
            @(negedge clk);
            set_as(m, 1'b1);
            return;
        end
        forever begin
            @(negedge clk);
            lat++;
            if ((m == 0 ? m0_dtack : m1_dtack) == 1'b0) break;
            if (lat >= 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL dtack_timeout: master %0d got no dtack in %0d clocks", m, lat);
                break;
            end
        end
        set_as(m, 1'b1);
    endtask

    // Monitor: samples just after each rising edge.
    logic        prev_dt [2];
    logic [15:0] last_din [2];
    logic        prev_ras = 1'b1;
    logic [AW-1:0] snap_adr;
    logic [18:0]   snap_ctl;

    task automatic mon_master(input int m);
        logic        dt, as_s;
        logic [15:0] din;
        exp_t        e;
        dt   = (m == 0) ? m0_dtack : m1_dtack;
        as_s = (m == 0) ? m0_as : m1_as;
        din  = (m == 0) ? m0_dat_in : m1_dat_in;
        if (!prev_dt[m]) begin
            check("dtack_hold_or_release", 32'(dt), 32'(as_s));
        end else if (!dt) begin
            dt_log.push_back(m);
            if ((m == 0 ? q0.size() : q1.size()) == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_dtack: master %0d acknowledged with nothing pending", m);
            end else begin
                e = (m == 0) ? q0.pop_front() : q1.pop_front();
                if (e.rd) begin
                    check(m == 0 ? "m0_read_data" : "m1_read_data", 32'(din), 32'(e.data));
                    last_din[m] = e.data;
                end else begin
                    check("write_keeps_dat_in", 32'(din), 32'(last_din[m]));
                end
            end
        end
        prev_dt[m] = dt;
    endtask

    initial begin
        prev_dt[0] = 1'b1; prev_dt[1] = 1'b1;
        last_din[0] = '0; last_din[1] = '0;
        snap_adr = '0; snap_ctl = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_dt[0] = 1'b1; prev_dt[1] = 1'b1;
                last_din[0] = '0; last_din[1] = '0;
                hi_run = 100;
                prev_ras = 1'b1;
            end else begin
                check("dtack_exclusive", 32'(m0_dtack | m1_dtack), 32'd1);
                mon_master(0);
                mon_master(1);
                if (ram_as) begin
                    hi_run++;
                end else if (prev_ras) begin
                    check("ram_as_gap_min", 32'(hi_run >= int'(GAP)), 32'd1);
                    last_gap = hi_run;
                    hi_run   = 0;
                    snap_adr = ram_adr;
                    snap_ctl = {ram_rw, ram_uds, ram_lds, ram_dat_out};
                end else begin
                    check("ram_adr_stable", ram_adr, snap_adr);
                    check("ram_ctl_stable", 32'({ram_rw, ram_uds, ram_lds, ram_dat_out}),
                          32'(snap_ctl));
                end
                prev_ras = ram_as;
            end
        end
    end

    int lat_a, lat_b, lat_c, lat_d;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
        ref_mem[8] = 16'h1234;
        ref_mem[9] = 16'h5678;

        repeat (3) @(negedge clk);
        check("rst_ram_as", 32'(ram_as), 32'd1);
        check("rst_ram_uds", 32'(ram_uds), 32'd1);
        check("rst_ram_lds", 32'(ram_lds), 32'd1);
        check("rst_ram_rw", 32'(ram_rw), 32'd1);
        check("rst_ram_adr", ram_adr, 32'd0);
        check("rst_ram_dat_out", 32'(ram_dat_out), 32'd0);
        check("rst_m0_dtack", 32'(m0_dtack), 32'd1);
        check("rst_m1_dtack", 32'(m1_dtack), 32'd1);
        check("rst_m0_dat_in", 32'(m0_dat_in), 32'd0);
        check("rst_m1_dat_in", 32'(m1_dat_in), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // m0 read, dtack held for a few clocks before the master lets go.
        access(0, 32'h10, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, lat_a);
        set_as(0, 1'b0);
        repeat (3) @(negedge clk);
        set_as(0, 1'b1);
        check("m0_read_latency", 32'(lat_a), 32'd4);
        repeat (4) @(negedge clk);

        // Upper-byte write from m1, then read back.
        access(1, 32'h20, 1'b0, 1'b0, 1'b1, 16'hABCD, 1'b0, lat_a);
        repeat (3) @(negedge clk);
        check("byte_write_mem", 32'(ram_mem[16]), 32'h0000AB00);
        access(1, 32'h20, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, lat_a);
        repeat (4) @(negedge clk);

        // Both masters requesting continuously: grants alternate starting with m0.
        dt_log.delete();
        fork
            begin
                for (int i = 0; i < 2; i++) access(0, 32'h10, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, lat_b);
            end
            begin
                for (int i = 0; i < 2; i++) access(1, 32'h12, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, lat_c);
            end
        join
        @(negedge clk);
        check("tie_grants", 32'(dt_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < dt_log.size(); i++) check("tie_order", 32'(dt_log[i]), 32'(i % 2));
        repeat (4) @(negedge clk);

        // Back-to-back m0 reads with the second request already pending.
        access(0, 32'h10, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, lat_a);
        access(0, 32'h12, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, lat_b);
        check("b2b_first_latency", 32'(lat_a), 32'd4);
        check("b2b_second_latency", 32'(lat_b), 32'd4);
        check("b2b_gap_exact", 32'(last_gap), 32'(GAP));
        repeat (4) @(negedge clk);

        // m1 aborts a write one clock after grant.
        access(1, 32'h30, 1'b0, 1'b0, 1'b0, 16'h5A5A, 1'b1, lat_a);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_m1_dtack_high", 32'(m1_dtack), 32'd1);
        end
        access(0, 32'h30, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, lat_a);
        check("after_abort_latency", 32'(lat_a), 32'd4);
        repeat (4) @(negedge clk);

        // Reset during ACT0 with m0_as held low across release.
        fork
            access(0, 32'h10, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, lat_d);
            begin
                repeat (3) @(negedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                check("midrst_ram_as", 32'(ram_as), 32'd1);
                check("midrst_m0_dtack", 32'(m0_dtack), 32'd1);
                check("midrst_m1_dtack", 32'(m1_dtack), 32'd1);
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        check("regrant_latency", 32'(lat_d), 32'd7);
        repeat (4) @(negedge clk);

        // Random traffic, each master in its own address region.
        fork
            begin
                int la;
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    access(0, 32'(2 * $urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           16'($urandom), 1'b0, la);
                end
            end
            begin
                int lb;
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    access(1, 32'(128 + 2 * $urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           16'($urandom), 1'b0, lb);
                end
            end
        join
        repeat (6) @(negedge clk);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tg68_ram_arbiter.md
# tg68_ram_arbiter

Two-master arbiter that shares one 68000-style asynchronous-bus RAM port (active-low AS/UDS/LDS/DTACK, RW high = read) between two TG68-style requesters, e.g. CPU and a DMA/bench master. It sits between the requesters and the simple bench RAM model in the CPU/cache/SDRAM bench. It sequences each access to completion, enforces the RAM's inter-cycle recovery gap and alternates grants round-robin.

## Interface
Parameters:
- AW, 32, address width of all address ports
- GAP, 2, minimum clocks ram_as is held high between downstream cycles (≥2 required by the RAM's two-stage ack pipeline)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- m0_as, m1_as  in  1  master address strobe, active low
- m0_adr, m1_adr  in  AW  byte address
- m0_rw, m1_rw  in  1  1 = read, 0 = write
- m0_uds/m0_lds, m1_uds/m1_lds  in  1  byte-lane strobes, active low
- m0_dat_out, m1_dat_out  in  16  write data
- m0_dat_in, m1_dat_in  out  16  registered read data
- m0_dtack, m1_dtack  out  1  registered cycle acknowledge, active low
- ram_as, ram_rw, ram_uds, ram_lds  out  1  registered downstream strobes
- ram_adr  out  AW  registered downstream address
- ram_dat_out  out  16  registered downstream write data
- ram_dat_in  in  16  downstream read data
- ram_dtack  in  1  downstream acknowledge, active low

## Operation
- States: IDLE, ACT0, ACT1, DONE0, DONE1. `last` pointer records the last granted master. `gap` counter counts ram_as high time, saturating at GAP.
- IDLE: grant only when gap == GAP. Request = mX_as low. One requester: grant it. Both: grant the master ≠ last. On grant, latch adr/rw/uds/lds/dat_out into ram_*, drive ram_as low, set last = X, go ACTX.
- ACTX: on ram_dtack low:
  - capture ram_dat_in into mX_dat_in (reads only; writes leave it unchanged),
  - drive ram_as high, clear gap to 0,
  - if mX_as is still low, drive mX_dtack low and go DONEX; else (master aborted) drop the result, leave mX_dtack high and go IDLE.
- DONEX: hold mX_dtack low until mX_as is sampled high, then drive mX_dtack high and go IDLE.
- While ram_as is high, gap increments each clock, saturating at GAP.
- Non-granted master's dtack is always high. dat_in holds its last value.
- ram_uds/ram_lds follow the latched request; ram_rw/adr/data are stable for the whole downstream cycle.
- Changes to master inputs after grant are ignored until the next grant.

## Timing
- Reset values:
  - state IDLE, last = 1 (m0 wins the first tie), gap = GAP,
  - ram_as/ram_uds/ram_lds/ram_rw = 1, ram_adr = 0, ram_dat_out = 0,
  - m0_dtack/m1_dtack = 1, m0_dat_in/m1_dat_in = 0.
- Reset assertion mid-cycle forces all of the above immediately (asynchronously). A master still holding as low after reset release is treated as a new request.
- Latency with the bench RAM (dtack two clocks after as): request sampled at edge E0 → ram_as low after E0 → ram_dtack low after E2 → mX_dtack low and ram_as high after E3.
- Release: mX_as high sampled at edge En → mX_dtack high after En.
- Back-to-back: next grant no earlier than GAP clocks of ram_as high after E3. With GAP=2 and an already-pending request, the next ram_as falls after E5.
- Simultaneous release of one master and a new request from the other in the same cycle: the release is processed that edge, and the grant occurs at the first IDLE edge with gap == GAP.

## Test plan
- Read m0: preload word 0x1234 at adr 0x10 → m0_as low at E0, m0_rw=1 → m0_dtack low after E3, m0_dat_in=0x1234. Stays low until m0_as high.
- Byte write m1: adr 0x20, dat 0xABCD, uds=0, lds=1 over word 0x0000 → memory reads back 0xAB00. m0_dtack stays high throughout.
- Tie: both masters request continuously after reset → grants m0, m1, m0, m1. Each ram_as low phase is preceded by ≥2 clocks high.
- Back-to-back m0 reads at 0x10 then 0x12 → second ram_as falls exactly GAP clocks after first rises. No early dtack; both data values are correct.
- Abort: m1 raises as one clock after grant → downstream cycle completes, m1_dtack never goes low, arbiter returns to IDLE, and the next m0 request is served normally.
- Reset mid-ACT0: rst_n low → ram_as, m0_dtack, m1_dtack high immediately and state IDLE. After release, a held m0_as is re-granted.
